// File: rtl/stream_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package stream_pkg;

    // FSM encoding, kept as plain vectors so older blocks can consume it directly.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Channel index width that never collapses to zero bits.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr+1, or fixed lowest-index priority.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  FIXED_PRIO = 0,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] idx;
    logic            found;

    // Scan candidates in priority order; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (FIXED_PRIO != 0)
                idx = CH_W'(i);
            else
                idx = CH_W'((int'(ptr) + 1 + i) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream mux with registered valid/ready output.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter int  NUM_CH     = 4,
    parameter int  FIXED_PRIO = 0,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("stream_mux_rr: NUM_CH must be in 2..16");
    end

    logic [NUM_CH-1:0][WIDTH-1:0] din;
    logic [0:0]                   state;
    logic [CH_W-1:0]              lock_ch;
    logic [CH_W-1:0]              rr_ptr;
    logic [NUM_CH-1:0]            arb_gnt;
    logic [CH_W-1:0]              arb_idx;
    logic [CH_W-1:0]              g;
    logic                         gnt_ok;
    logic                         load;
    logic                         xfer;

    assign din = in_data;

    rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign load = !out_valid || out_ready;

    // Locked packets pin the grant; otherwise the arbiter picks among requesters.
    always_comb begin
        if (state == ST_LOCKED) begin
            g      = lock_ch;
            gnt_ok = 1'b1;
        end else begin
            g      = arb_idx;
            gnt_ok = |arb_gnt;
        end
    end

    // Only the granted channel sees ready; independent of its own valid once locked.
    always_comb begin
        in_ready = '0;
        if (gnt_ok && load)
            in_ready[g] = 1'b1;
    end

    assign xfer = gnt_ok && load && in_valid[g];

    // Output beat register: load on transfer, empty on idle load, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= din[g];
                out_last  <= in_last[g];
                out_ch    <= g;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Packet lock FSM and round-robin pointer; pointer moves only on packet completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
            rr_ptr  <= CH_W'(NUM_CH - 1);
        end else if (xfer) begin
            if (in_last[g]) begin
                state  <= ST_IDLE;
                rr_ptr <= g;
            end else begin
                state   <= ST_LOCKED;
                lock_ch <= g;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed and scoreboarded bench for stream_mux_rr (RR, fixed-priority and wide configs).
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    // Round-robin, 4 x 8-bit
    logic [3:0]  iv, il, ir;
    logic [31:0] id;
    logic        ov, ol, ordy;
    logic [7:0]  od;
    logic [1:0]  och;

    // Fixed priority, 4 x 8-bit
    logic [3:0]  f_iv, f_il, f_ir;
    logic [31:0] f_id;
    logic        f_ov, f_ol, f_ordy;
    logic [7:0]  f_od;
    logic [1:0]  f_och;

    // Round-robin, 2 x 32-bit
    logic [1:0]  w_iv, w_il, w_ir;
    logic [63:0] w_id;
    logic        w_ov, w_ol, w_ordy;
    logic [31:0] w_od;
    logic [0:0]  w_och;

    stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .in_valid(iv), .in_data(id), .in_last(il), .in_ready(ir),
        .out_valid(ov), .out_data(od), .out_last(ol), .out_ch(och), .out_ready(ordy));

    stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .in_valid(f_iv), .in_data(f_id), .in_last(f_il), .in_ready(f_ir),
        .out_valid(f_ov), .out_data(f_od), .out_last(f_ol), .out_ch(f_och), .out_ready(f_ordy));

    stream_mux_rr #(.WIDTH(32), .NUM_CH(2), .FIXED_PRIO(0)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_iv), .in_data(w_id), .in_last(w_il), .in_ready(w_ir),
        .out_valid(w_ov), .out_data(w_od), .out_last(w_ol), .out_ch(w_och), .out_ready(w_ordy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        compared++;
        if (ov !== 1'b0) begin mismatched++; $display("FAIL reset_ov: got %b want 0", ov); end
        rst = 1'b0;
        tick();
        compared++;
        if ({ov, od, och, ir} !== 15'd0) begin
            mismatched++; $display("FAIL reset_state: got ov=%b od=%h och=%0d ir=%b want all 0", ov, od, och, ir);
        end
        compared++;
        if ({f_ov, w_ov} !== 2'b00) begin mismatched++; $display("FAIL reset_others: got %b want 00", {f_ov, w_ov}); end
        // load a beat then reset asynchronously mid-cycle
        iv = 4'b0100; il = 4'b0100; id = 32'h0077_0000; ordy = 1'b0;
        tick();
        compared++;
        if ({ov, och, od} !== {1'b1, 2'd2, 8'h77}) begin
            mismatched++; $display("FAIL pre_reset_beat: got ov=%b och=%0d od=%h want 1/2/77", ov, och, od);
        end
        #3; rst = 1'b1; #1;
        compared++;
        if ({ov, od, och} !== 11'd0) begin
            mismatched++; $display("FAIL async_reset: got ov=%b od=%h och=%0d want 0/00/0", ov, od, och);
        end
        iv = '0; il = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        iv = 4'b1111; il = 4'b1111; id = 32'hC3C2_C1C0; ordy = 1'b1;
        #1;
        compared++;
        if (ir !== 4'b0001) begin mismatched++; $display("FAIL first_grant: got ir=%b want 0001", ir); end
        for (int k = 0; k < 5; k++) begin
            tick();
            compared++;
            if ({ov, och, od} !== {1'b1, 2'(k % 4), 8'(8'hC0 + k % 4)}) begin
                mismatched++;
                $display("FAIL rr_seq[%0d]: got ov=%b och=%0d od=%h want 1/%0d/%h", k, ov, och, od, k % 4, 8'hC0 + k % 4);
            end
        end
        iv = '0; il = '0;
    endtask

    task automatic test_backpressure();
        tick();
        compared++;
        if (ov !== 1'b0) begin mismatched++; $display("FAIL bp_drain: got ov=%b want 0", ov); end
        ordy = 1'b0; iv = 4'b0010; il = 4'b0010; id = 32'h0000_A500;
        tick();
        compared++;
        if ({ov, och, od} !== {1'b1, 2'd1, 8'hA5}) begin
            mismatched++; $display("FAIL bp_first: got ov=%b och=%0d od=%h want 1/1/a5", ov, och, od);
        end
        id = 32'h0000_5A00;
        for (int k = 0; k < 3; k++) begin
            #1;
            compared++;
            if ({ov, od, ir} !== {1'b1, 8'hA5, 4'b0000}) begin
                mismatched++; $display("FAIL bp_hold[%0d]: got ov=%b od=%h ir=%b want 1/a5/0000", k, ov, od, ir);
            end
            tick();
        end
        ordy = 1'b1;
        #1;
        compared++;
        if (ir !== 4'b0010) begin mismatched++; $display("FAIL bp_release_ready: got %b want 0010", ir); end
        tick();
        iv = '0; il = '0;
        compared++;
        if ({ov, od, ol} !== {1'b1, 8'h5A, 1'b1}) begin
            mismatched++; $display("FAIL bp_no_bubble: got ov=%b od=%h ol=%b want 1/5a/1", ov, od, ol);
        end
        tick();
        compared++;
        if (ov !== 1'b0) begin mismatched++; $display("FAIL bp_empty: got ov=%b want 0", ov); end
    endtask

    task automatic test_packet_lock();
        // ptr now at 1: ch2 is first in line ahead of ch3 and ch0
        iv = 4'b1101; il = 4'b1001; id = 32'h3310_00C0; ordy = 1'b1;
        #1;
        compared++;
        if (ir !== 4'b0100) begin mismatched++; $display("FAIL lock_grant: got ir=%b want 0100", ir); end
        tick();
        compared++;
        if ({ov, och, od, ol} !== {1'b1, 2'd2, 8'h10, 1'b0}) begin
            mismatched++; $display("FAIL lock_beat0: got ov=%b och=%0d od=%h ol=%b want 1/2/10/0", ov, och, od, ol);
        end
        id[23:16] = 8'h11;
        tick();
        compared++;
        if ({ov, och, od} !== {1'b1, 2'd2, 8'h11}) begin
            mismatched++; $display("FAIL lock_beat1: got ov=%b och=%0d od=%h want 1/2/11", ov, och, od);
        end
        iv[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            compared++;
            if (ir !== 4'b0100) begin mismatched++; $display("FAIL lock_gap_ready[%0d]: got %b want 0100", k, ir); end
            tick();
            compared++;
            if (ov !== 1'b0) begin mismatched++; $display("FAIL lock_gap_idle[%0d]: got ov=%b och=%0d want ov=0", k, ov, och); end
        end
        iv[2] = 1'b1; il[2] = 1'b1; id[23:16] = 8'h12;
        tick();
        compared++;
        if ({ov, och, od, ol} !== {1'b1, 2'd2, 8'h12, 1'b1}) begin
            mismatched++; $display("FAIL lock_beat2: got ov=%b och=%0d od=%h ol=%b want 1/2/12/1", ov, och, od, ol);
        end
        iv[2] = 1'b0;
        #1;
        compared++;
        if (ir !== 4'b1000) begin mismatched++; $display("FAIL lock_next_ready: got %b want 1000", ir); end
        tick();
        compared++;
        if ({ov, och, od} !== {1'b1, 2'd3, 8'h33}) begin
            mismatched++; $display("FAIL lock_next: got ov=%b och=%0d od=%h want 1/3/33", ov, och, od);
        end
        iv = '0; il = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        iv = 4'b0010; il = 4'b0000; id = 32'h0000_4000; ordy = 1'b1;
        tick();
        compared++;
        if ({ov, och, od, ol} !== {1'b1, 2'd1, 8'h40, 1'b0}) begin
            mismatched++; $display("FAIL mid_first: got ov=%b och=%0d od=%h ol=%b want 1/1/40/0", ov, och, od, ol);
        end
        #2; rst = 1'b1; #1;
        compared++;
        if (ov !== 1'b0) begin mismatched++; $display("FAIL mid_discard: got ov=%b want 0", ov); end
        @(posedge clk); #1;
        rst = 1'b0;
        iv = 4'b0011; il = 4'b0011; id = 32'h0000_B1B0;
        #1;
        compared++;
        if (ir !== 4'b0001) begin mismatched++; $display("FAIL mid_regrant_ready: got %b want 0001", ir); end
        tick();
        compared++;
        if ({ov, och, od} !== {1'b1, 2'd0, 8'hB0}) begin
            mismatched++; $display("FAIL mid_regrant: got ov=%b och=%0d od=%h want 1/0/b0", ov, och, od);
        end
        iv = '0; il = '0;
        tick();
    endtask

    task automatic test_fixed_prio();
        f_ordy = 1'b1; f_iv = 4'b1010; f_il = 4'b1010; f_id = 32'h3300_1100;
        #1;
        compared++;
        if (f_ir !== 4'b0010) begin mismatched++; $display("FAIL fp_ready: got %b want 0010", f_ir); end
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if ({f_ov, f_och, f_od} !== {1'b1, 2'd1, 8'h11}) begin
                mismatched++; $display("FAIL fp_ch1[%0d]: got ov=%b och=%0d od=%h want 1/1/11", k, f_ov, f_och, f_od);
            end
        end
        f_iv = 4'b1000;
        tick();
        compared++;
        if ({f_ov, f_och, f_od} !== {1'b1, 2'd3, 8'h33}) begin
            mismatched++; $display("FAIL fp_ch3: got ov=%b och=%0d od=%h want 1/3/33", f_ov, f_och, f_od);
        end
        f_iv = 4'b1010;
        tick();
        compared++;
        if ({f_ov, f_och} !== {1'b1, 2'd1}) begin
            mismatched++; $display("FAIL fp_back_ch1: got ov=%b och=%0d want 1/1", f_ov, f_och);
        end
        f_iv = '0; f_il = '0;
        tick();
        compared++;
        if (f_ov !== 1'b0) begin mismatched++; $display("FAIL fp_idle: got ov=%b want 0", f_ov); end
    endtask

    task automatic test_random_wide();
        logic [15:0] seq [2];
        logic [32:0] q0[$];
        logic [32:0] q1[$];
        logic [32:0] exp;
        logic        in_pkt, acc, s_ol;
        logic [0:0]  pkt_ch, s_och;
        logic [31:0] s_od;
        logic [1:0]  xin, s_il;
        logic [63:0] s_id;
        seq[0] = '0; seq[1] = '0; in_pkt = 1'b0; pkt_ch = '0;
        w_iv = '0; w_il = '0; w_id = '0; w_ordy = 1'b0;
        for (int cyc = 0; cyc < 2012; cyc++) begin
            w_ordy = (cyc >= 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 2; c++) begin
                if (cyc < 2000 && !w_iv[c] && $urandom_range(0, 1) == 1) begin
                    w_iv[c] = 1'b1;
                    w_id[c*32 +: 32] = {16'(c), seq[c]};
                    w_il[c] = ($urandom_range(0, 2) == 0);
                end
            end
            #1;
            compared++;
            if (!$onehot0(w_ir)) begin mismatched++; $display("FAIL rnd_onehot[%0d]: got ir=%b want onehot0", cyc, w_ir); end
            acc = w_ov && w_ordy; s_od = w_od; s_ol = w_ol; s_och = w_och;
            xin = w_iv & w_ir; s_id = w_id; s_il = w_il;
            @(posedge clk); #1;
            if (acc) begin
                compared++;
                if (in_pkt && s_och !== pkt_ch) begin
                    mismatched++; $display("FAIL rnd_contig[%0d]: got ch=%0d want ch=%0d", cyc, s_och, pkt_ch);
                end
                in_pkt = !s_ol; pkt_ch = s_och;
                compared++;
                if ((s_och == 1'b0 && q0.size() == 0) || (s_och == 1'b1 && q1.size() == 0)) begin
                    mismatched++; $display("FAIL rnd_spurious[%0d]: got beat %h on ch%0d want none", cyc, s_od, s_och);
                end else begin
                    exp = (s_och == 1'b0) ? q0.pop_front() : q1.pop_front();
                    if ({s_ol, s_od} !== exp) begin
                        mismatched++; $display("FAIL rnd_order[%0d]: got %h want %h", cyc, {s_ol, s_od}, exp);
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (xin[c]) begin
                    if (c == 0) q0.push_back({s_il[c], s_id[31:0]});
                    else        q1.push_back({s_il[c], s_id[63:32]});
                    seq[c] = seq[c] + 16'd1;
                    w_iv[c] = (cyc < 2000) && ($urandom_range(0, 1) == 1);
                    if (w_iv[c]) begin
                        w_id[c*32 +: 32] = {16'(c), seq[c]};
                        w_il[c] = ($urandom_range(0, 2) == 0);
                    end
                end
            end
        end
        compared++;
        if (q0.size() + q1.size() != 0) begin
            mismatched++; $display("FAIL rnd_leftover: got %0d beats undelivered want 0", q0.size() + q1.size());
        end
        w_iv = '0; w_il = '0;
    endtask

    initial begin
        rst = 1'b1;
        iv = '0; il = '0; id = '0; ordy = 1'b0;
        f_iv = '0; f_il = '0; f_id = '0; f_ordy = 1'b0;
        w_iv = '0; w_il = '0; w_id = '0; w_ordy = 1'b0;
        test_reset();
        test_backpressure();
        test_packet_lock();
        test_reset_mid_packet();
        test_fixed_prio();
        test_random_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
